// File: rtl/clock_pkg.sv
// Shared clock constants, BCD digit limits and the 24->12 hour conversion
// used by both the time-of-day counter and the date display path.
package clock_pkg;

  localparam int SEC1_MAX_DEFAULT = 50_000_000;

  localparam int DIGIT_MAX  = 9;
  localparam int SEC_H_MAX  = 5;
  localparam int MIN_H_MAX  = 5;
  localparam int HOUR_MAX_H = 2;
  localparam int HOUR_MAX_L = 3;

  typedef struct packed {
    logic       pm;
    logic       hour_h;
    logic [3:0] hour_l;
  } h12_t;

  // Expects a valid 00..23 BCD hour; midnight and noon both display as 12.
  function automatic h12_t to_h12(input logic [1:0] hh, input logic [3:0] hl);
    logic [4:0] hr;
    logic [4:0] h12;
    h12_t       r;
    hr   = 5'(hh) * 5'd10 + 5'(hl);
    r.pm = (hr >= 5'd12);
    h12  = r.pm ? hr - 5'd12 : hr;
    if (h12 == 5'd0) h12 = 5'd12;
    r.hour_h = (h12 >= 5'd10);
    r.hour_l = r.hour_h ? 4'(h12 - 5'd10) : h12[3:0];
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One modulo-(MAX+1) BCD digit: increments on inc_i, synchronous load wins,
// carry_o flags the increment that wraps the digit back to zero.
module bcd_digit_cnt #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] val_o,
  output logic         carry_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = ld_val_i;
    end else if (inc_i) begin
      val_d = (val_q == MAX_V) ? '0 : val_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) val_q <= '0;
    else       val_q <= val_d;
  end

  assign val_o   = val_q;
  assign carry_o = inc_i && (val_q == MAX_V);

endmodule

// File: rtl/cnt_hms.sv
// BCD time-of-day counter 00:00:00..23:59:59 with one-second prescaler,
// validated parallel load and midnight day carry. Optional CNT_HMS_H12_EN adds a 12-hour view.
import clock_pkg::*;

module cnt_hms #(
  parameter int SEC1_MAX = SEC1_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [1:0] ld_hour_h_i,
  input  logic [3:0] ld_hour_l_i,
  input  logic [2:0] ld_min_h_i,
  input  logic [3:0] ld_min_l_i,
  input  logic [2:0] ld_sec_h_i,
  input  logic [3:0] ld_sec_l_i,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] min_h_o,
  output logic [3:0] min_l_o,
  output logic [2:0] sec_h_o,
  output logic [3:0] sec_l_o,
  output logic       enable_o,
  output logic       day_carry_o,
`ifdef CNT_HMS_H12_EN
  output logic       disp_hour_h_o,
  output logic [3:0] disp_hour_l_o,
  output logic       pm_o,
`endif
  output logic       load_err_o
);

  localparam int            PW       = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(SEC1_MAX - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          load_err_q;

  logic ld_hour_ok;
  logic ld_valid;
  logic load_ok;

  logic sec_l_carry, sec_h_carry, min_l_carry, min_h_carry;
  logic hour_l_carry, hour_h_carry;
  logic hour_wrap;
  logic hour_load;

  assign ld_hour_ok = (ld_hour_h_i < 2'(HOUR_MAX_H)) ? (ld_hour_l_i <= 4'(DIGIT_MAX))
                    : (ld_hour_h_i == 2'(HOUR_MAX_H)) && (ld_hour_l_i <= 4'(HOUR_MAX_L));

  assign ld_valid = ld_hour_ok
                 && (ld_min_h_i <= 3'(MIN_H_MAX)) && (ld_min_l_i <= 4'(DIGIT_MAX))
                 && (ld_sec_h_i <= 3'(SEC_H_MAX)) && (ld_sec_l_i <= 4'(DIGIT_MAX));

  assign load_ok  = load_i && ld_valid;

  // Any LOAD, even a rejected one, masks the strobe for that cycle.
  assign enable_o = (presc_q == PRE_TERM) && !load_i;

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (load_ok || presc_q == PRE_TERM) presc_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      load_err_q <= load_i && !ld_valid;
    end
  end

  assign load_err_o = load_err_q;

  bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX)) u_sec_l (
    .clk_i, .rst_i, .inc_i(enable_o), .load_i(load_ok), .ld_val_i(ld_sec_l_i),
    .val_o(sec_l_o), .carry_o(sec_l_carry)
  );

  bcd_digit_cnt #(.W(3), .MAX(SEC_H_MAX)) u_sec_h (
    .clk_i, .rst_i, .inc_i(sec_l_carry), .load_i(load_ok), .ld_val_i(ld_sec_h_i),
    .val_o(sec_h_o), .carry_o(sec_h_carry)
  );

  bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX)) u_min_l (
    .clk_i, .rst_i, .inc_i(sec_h_carry), .load_i(load_ok), .ld_val_i(ld_min_l_i),
    .val_o(min_l_o), .carry_o(min_l_carry)
  );

  bcd_digit_cnt #(.W(3), .MAX(MIN_H_MAX)) u_min_h (
    .clk_i, .rst_i, .inc_i(min_l_carry), .load_i(load_ok), .ld_val_i(ld_min_h_i),
    .val_o(min_h_o), .carry_o(min_h_carry)
  );

  // 23 -> 00 is forced through the load path; a tens carry (unreachable from valid states) also clears.
  assign hour_wrap = (min_h_carry && hour_h_o == 2'(HOUR_MAX_H) && hour_l_o == 4'(HOUR_MAX_L))
                  || hour_h_carry;
  assign hour_load = load_ok || hour_wrap;

  bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX)) u_hour_l (
    .clk_i, .rst_i, .inc_i(min_h_carry), .load_i(hour_load),
    .ld_val_i(hour_wrap ? 4'd0 : ld_hour_l_i),
    .val_o(hour_l_o), .carry_o(hour_l_carry)
  );

  bcd_digit_cnt #(.W(2), .MAX(HOUR_MAX_H)) u_hour_h (
    .clk_i, .rst_i, .inc_i(hour_l_carry), .load_i(hour_load),
    .ld_val_i(hour_wrap ? 2'd0 : ld_hour_h_i),
    .val_o(hour_h_o), .carry_o(hour_h_carry)
  );

  assign day_carry_o = enable_o
                    && hour_h_o == 2'(HOUR_MAX_H) && hour_l_o == 4'(HOUR_MAX_L)
                    && min_h_o == 3'(MIN_H_MAX) && min_l_o == 4'(DIGIT_MAX)
                    && sec_h_o == 3'(SEC_H_MAX) && sec_l_o == 4'(DIGIT_MAX);

`ifdef CNT_HMS_H12_EN
  h12_t h12;
  assign h12           = to_h12(hour_h_o, hour_l_o);
  assign disp_hour_h_o = h12.hour_h;
  assign disp_hour_l_o = h12.hour_l;
  assign pm_o          = h12.pm;
`endif

endmodule

// File: tb/tb_cnt_hms.sv
// Scoreboard bench for cnt_hms with SEC1_MAX=16; define CNT_HMS_H12_EN to also
// exercise the 12-hour display outputs.
module tb_cnt_hms;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [1:0] ld_hour_h;
  logic [3:0] ld_hour_l;
  logic [2:0] ld_min_h;
  logic [3:0] ld_min_l;
  logic [2:0] ld_sec_h;
  logic [3:0] ld_sec_l;
  logic [1:0] hour_h;
  logic [3:0] hour_l;
  logic [2:0] min_h;
  logic [3:0] min_l;
  logic [2:0] sec_h;
  logic [3:0] sec_l;
  logic       enable;
  logic       day_carry;
  logic       load_err;
`ifdef CNT_HMS_H12_EN
  logic       disp_hour_h;
  logic [3:0] disp_hour_l;
  logic       pm;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  cnt_hms #(.SEC1_MAX(16)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load),
    .ld_hour_h_i(ld_hour_h), .ld_hour_l_i(ld_hour_l),
    .ld_min_h_i(ld_min_h), .ld_min_l_i(ld_min_l),
    .ld_sec_h_i(ld_sec_h), .ld_sec_l_i(ld_sec_l),
    .hour_h_o(hour_h), .hour_l_o(hour_l),
    .min_h_o(min_h), .min_l_o(min_l),
    .sec_h_o(sec_h), .sec_l_o(sec_l),
    .enable_o(enable), .day_carry_o(day_carry),
`ifdef CNT_HMS_H12_EN
    .disp_hour_h_o(disp_hour_h), .disp_hour_l_o(disp_hour_l), .pm_o(pm),
`endif
    .load_err_o(load_err)
  );

  function automatic logic [19:0] hms(input logic [1:0] hh, input logic [3:0] hl,
                                      input logic [2:0] mh, input logic [3:0] ml,
                                      input logic [2:0] sh, input logic [3:0] sl);
    return {hh, hl, mh, ml, sh, sl};
  endfunction

  function automatic logic [19:0] cur();
    return {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_ld(input logic [19:0] t);
    ld_hour_h = t[19:18];
    ld_hour_l = t[17:14];
    ld_min_h  = t[13:11];
    ld_min_l  = t[10:7];
    ld_sec_h  = t[6:4];
    ld_sec_l  = t[3:0];
  endtask

  task automatic do_load(input logic [19:0] t);
    drive_ld(t);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Counts sample points until ENABLE is seen; cycles = -1 when the budget expires.
  task automatic wait_enable(input int limit, output int cycles);
    cycles = -1;
    for (int i = 0; i <= limit; i++) begin
      if (enable === 1'b1) begin
        cycles = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    load = 1'b0;
    drive_ld(20'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cur() !== 20'h0) begin
      n_err++; $display("FAIL reset_time got=%05h exp=%05h", cur(), 20'h0);
    end
    n_cmp++;
    if (enable !== 1'b0 || day_carry !== 1'b0 || load_err !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got en=%b dc=%b err=%b exp=0/0/0", enable, day_carry, load_err);
    end
    $display("reset: time=%05h en=%b", cur(), enable);
  endtask

  task automatic test_tick();
    logic [19:0] e;
    logic [3:0]  k = 4'd0;
    for (int n = 0; n < 48; n++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
          n_err++; $display("FAIL tick_time cycle=%0d got=%05h exp=%05h", n, cur(), e);
        end else $display("tick: cycle=%0d time=%05h", n, cur());
      end
      n_cmp++;
      if (enable !== (n % 16 == 15)) begin
        n_err++; $display("FAIL tick_enable cycle=%0d got=%b exp=%b", n, enable, (n % 16 == 15));
      end
      if (n % 16 == 15) begin
        k = k + 4'd1;
        exp_q.push_back(hms(0, 0, 0, 0, 0, k));
      end
      step();
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (cur() !== e) begin
      n_err++; $display("FAIL tick_time_last got=%05h exp=%05h", cur(), e);
    end else $display("tick: cycle=48 time=%05h", cur());
  endtask

  task automatic test_carry();
    logic [19:0] ld_tab[3];
    logic [19:0] ex_tab[3];
    logic [19:0] e;
    int cyc;
    ld_tab[0] = hms(0, 0, 5, 9, 5, 9); ex_tab[0] = hms(0, 1, 0, 0, 0, 0);
    ld_tab[1] = hms(0, 9, 5, 9, 5, 9); ex_tab[1] = hms(1, 0, 0, 0, 0, 0);
    ld_tab[2] = hms(1, 9, 5, 9, 5, 9); ex_tab[2] = hms(2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_load(ld_tab[i]);
      exp_q.push_back(ex_tab[i]);
      n_cmp++;
      if (cur() !== ld_tab[i]) begin
        n_err++; $display("FAIL carry_load got=%05h exp=%05h", cur(), ld_tab[i]);
      end
      wait_enable(40, cyc);
      n_cmp++;
      if (cyc !== 15) begin
        n_err++; $display("FAIL carry_period got=%0d exp=15", cyc);
      end
      n_cmp++;
      if (day_carry !== 1'b0) begin
        n_err++; $display("FAIL carry_daycarry got=%b exp=0", day_carry);
      end
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (cur() !== e) begin
        n_err++; $display("FAIL carry_result got=%05h exp=%05h", cur(), e);
      end else $display("carry: load=%05h -> %05h", ld_tab[i], cur());
    end
  endtask

  task automatic test_midnight();
    logic [19:0] e;
    int cyc;
    do_load(hms(2, 3, 5, 9, 5, 9));
    exp_q.push_back(20'h0);
    wait_enable(40, cyc);
    n_cmp++;
    if (cyc !== 15 || day_carry !== 1'b1) begin
      n_err++; $display("FAIL midnight_pulse got cyc=%0d dc=%b exp cyc=15 dc=1", cyc, day_carry);
    end
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (cur() !== e || day_carry !== 1'b0) begin
      n_err++; $display("FAIL midnight_wrap got=%05h dc=%b exp=%05h dc=0", cur(), day_carry, e);
    end else $display("midnight: time=%05h dc=%b", cur(), day_carry);
  endtask

  task automatic test_invalid();
    logic [19:0] bad[3];
    logic [19:0] base;
    logic [19:0] e;
    int cyc;
    base   = hms(1, 2, 0, 0, 0, 0);
    bad[0] = hms(2, 4, 0, 0, 0, 0);
    bad[1] = hms(1, 2, 6, 0, 0, 0);
    bad[2] = hms(1, 2, 0, 4'hA, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_load(base);
      repeat (3) step();
      do_load(bad[i]);
      n_cmp++;
      if (load_err !== 1'b1 || cur() !== base) begin
        n_err++; $display("FAIL invalid_reject got err=%b time=%05h exp err=1 time=%05h", load_err, cur(), base);
      end
      step();
      n_cmp++;
      if (load_err !== 1'b0) begin
        n_err++; $display("FAIL invalid_errwidth got=%b exp=0", load_err);
      end
      exp_q.push_back(hms(1, 2, 0, 0, 0, 1));
      wait_enable(40, cyc);
      n_cmp++;
      if (cyc !== 10) begin
        n_err++; $display("FAIL invalid_period got=%0d exp=10", cyc);
      end
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (cur() !== e) begin
        n_err++; $display("FAIL invalid_tick got=%05h exp=%05h", cur(), e);
      end else $display("invalid: load=%05h rejected, time=%05h", bad[i], cur());
    end
  endtask

  task automatic test_collision();
    logic [19:0] e;
    int cyc;
    do_load(20'h0);
    repeat (15) step();
    n_cmp++;
    if (enable !== 1'b1) begin
      n_err++; $display("FAIL collision_terminal got=%b exp=1", enable);
    end
    drive_ld(hms(0, 5, 0, 5, 0, 5));
    load = 1'b1;
    #1;
    n_cmp++;
    if (enable !== 1'b0 || day_carry !== 1'b0) begin
      n_err++; $display("FAIL collision_suppress got en=%b dc=%b exp 0/0", enable, day_carry);
    end
    step();
    load = 1'b0;
    n_cmp++;
    if (cur() !== hms(0, 5, 0, 5, 0, 5)) begin
      n_err++; $display("FAIL collision_load got=%05h exp=%05h", cur(), hms(0, 5, 0, 5, 0, 5));
    end
    exp_q.push_back(hms(0, 5, 0, 5, 0, 6));
    wait_enable(40, cyc);
    n_cmp++;
    if (cyc !== 15) begin
      n_err++; $display("FAIL collision_period got=%0d exp=15", cyc);
    end
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (cur() !== e) begin
      n_err++; $display("FAIL collision_tick got=%05h exp=%05h", cur(), e);
    end else $display("collision: time=%05h", cur());
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    int cyc;
    repeat (5) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cur() !== 20'h0 || enable !== 1'b0) begin
      n_err++; $display("FAIL midreset_clear got=%05h en=%b exp=00000 en=0", cur(), enable);
    end
    step();
    rst = 1'b0;
    exp_q.push_back(hms(0, 0, 0, 0, 0, 1));
    wait_enable(40, cyc);
    n_cmp++;
    if (cyc !== 15) begin
      n_err++; $display("FAIL midreset_period got=%0d exp=15", cyc);
    end
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if (cur() !== e) begin
      n_err++; $display("FAIL midreset_tick got=%05h exp=%05h", cur(), e);
    end else $display("midreset: time=%05h", cur());
  endtask

`ifdef CNT_HMS_H12_EN
  task automatic test_h12();
    logic [19:0] ld_tab[5];
    logic [5:0]  ex_tab[5];
    logic [5:0]  e;
    ld_tab[0] = hms(0, 0, 0, 0, 0, 0); ex_tab[0] = {1'b1, 4'd2, 1'b0};
    ld_tab[1] = hms(1, 2, 0, 0, 0, 0); ex_tab[1] = {1'b1, 4'd2, 1'b1};
    ld_tab[2] = hms(2, 3, 0, 0, 0, 0); ex_tab[2] = {1'b1, 4'd1, 1'b1};
    ld_tab[3] = hms(0, 1, 0, 0, 0, 0); ex_tab[3] = {1'b0, 4'd1, 1'b0};
    ld_tab[4] = hms(1, 3, 0, 0, 0, 0); ex_tab[4] = {1'b0, 4'd1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_load(ld_tab[i]);
      e = ex_tab[i];
      n_cmp++;
      if ({disp_hour_h, disp_hour_l, pm} !== e) begin
        n_err++; $display("FAIL h12_view load=%05h got=%b%h pm=%b exp=%b%h pm=%b",
                          ld_tab[i], disp_hour_h, disp_hour_l, pm, e[5], e[4:1], e[0]);
      end else $display("h12: load=%05h disp=%b%h pm=%b", ld_tab[i], disp_hour_h, disp_hour_l, pm);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    drive_ld(20'h0);
    test_reset();
    test_tick();
    test_carry();
    test_midnight();
    test_invalid();
    test_collision();
    test_reset_mid();
`ifdef CNT_HMS_H12_EN
    test_h12();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnt_hms.md
# cnt_hms

Time-of-day counter for the digital clock. It divides CLK down to a one-second ENABLE strobe and counts seconds, minutes and hours in BCD from 00:00:00 to 23:59:59. It sits directly upstream of the day/month/year counter and feeds it the shared ENABLE strobe and a DAY_CARRY pulse on midnight rollover. It also accepts a validated parallel time load from the setting logic.

## Interface
- SEC1_MAX, 50_000_000: CLK cycles per second. Prescaler period. Simulation uses 16. Minimum 2.
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state
- LOAD  in  1  one-cycle request to load LD_* digits
- LD_HOUR_H  in  2  hour tens, BCD
- LD_HOUR_L  in  4  hour units, BCD
- LD_MIN_H  in  3  minute tens
- LD_MIN_L  in  4  minute units
- LD_SEC_H  in  3  second tens
- LD_SEC_L  in  4  second units
- HOUR_H / HOUR_L  out  2 / 4  current hour, BCD
- MIN_H / MIN_L  out  3 / 4  current minute
- SEC_H / SEC_L  out  3 / 4  current second
- ENABLE  out  1  one-cycle one-second strobe
- DAY_CARRY  out  1  one-cycle pulse, coincident with ENABLE, at 23:59:59
- LOAD_ERR  out  1  registered one-cycle pulse when a LOAD was rejected

## Operation
- Prescaler counts 0..SEC1_MAX-1 and wraps to 0. ENABLE = (prescaler == SEC1_MAX-1) && !LOAD (combinational from the register).
- Time digits advance on the rising edge where ENABLE=1:
  - SEC_L 0..9 carries into SEC_H 0..5.
  - The second carry increments MIN_L/MIN_H (00..59).
  - The minute carry increments the hour, 00..23. At 23 the hour wraps to 00. It does not wrap at 29.
- DAY_CARRY = ENABLE && time == 23:59:59. The downstream date counter advances on the same edge.
- LOAD is valid when every units nibble ≤ 9, MIN_H ≤ 5, SEC_H ≤ 5, and the hour is ≤ 23.
  - Valid LOAD: digits take the LD_* values and the prescaler clears to 0.
  - Invalid LOAD: no state changes, the prescaler continues, and LOAD_ERR=1 on the next cycle.
- LOAD coincident with the terminal prescaler count: LOAD wins. ENABLE and DAY_CARRY are suppressed and no increment occurs. After a valid load, the next ENABLE comes a full SEC1_MAX cycles later.
- Reset values: all digits 0 (00:00:00), prescaler 0, ENABLE 0, DAY_CARRY 0, LOAD_ERR 0.
- RESET mid-second discards the partial second. The first ENABLE after release comes SEC1_MAX cycles later.

## Timing
- The first ENABLE occurs on cycle SEC1_MAX-1 after RESET deassertion (cycle 0 = first edge with RESET low). After that, ENABLE repeats every SEC1_MAX cycles.
- Digit outputs are registered. They show the new value one cycle after the ENABLE edge and hold until the next ENABLE or LOAD.
- LOAD to outputs: 1 cycle. LOAD to LOAD_ERR: 1 cycle, width 1.
- Digit outputs and DAY_CARRY are glitch-free relative to ENABLE, so the downstream stage may sample them on any CLK edge.

## Configuration
- CNT_HMS_H12_EN defined: adds outputs DISP_HOUR_H (1 bit), DISP_HOUR_L (4 bits) and PM (1 bit). These give a combinational 12-hour view of the registered 24-hour count:
  - 00 → 12 AM
  - 01–11 → unchanged, AM
  - 12 → 12 PM
  - 13–23 → 01–11 PM
- Internal counting, DAY_CARRY and LOAD stay in 24-hour format.
- Not defined: these three ports and their logic are absent.

## Structure
- Shared package clock_pkg holds:
  - BCD limit constants: SEC_H_MAX=5, MIN_H_MAX=5, HOUR_MAX_H=2, HOUR_MAX_L=3, DIGIT_MAX=9.
  - The default SEC1_MAX.
  - The 24→12 hour conversion function, which the date display path reuses.
- One sub-module, bcd_digit_cnt:
  - Parameterised modulo-N BCD digit with inc/carry-in, synchronous load, and carry-out.
  - Instantiated for each digit.
  - Hour wrap logic stays in cnt_hms.

## Test plan
- Reset and tick (SEC1_MAX=16): hold RESET 3 cycles, then release → outputs 00:00:00. ENABLE pulses 1 cycle wide at cycles 15, 31, 47. SEC_L reads 1, 2, 3 after each pulse.
- Minute and hour carry: LOAD 00:59:59 → next ENABLE gives 01:00:00. LOAD 09:59:59 → next ENABLE gives 10:00:00. DAY_CARRY stays 0 in both cases.
- Midnight: LOAD 23:59:59 → exactly 16 cycles later ENABLE=1 and DAY_CARRY=1 in the same cycle. Next cycle reads 00:00:00 and DAY_CARRY returns to 0.
- Invalid load:
  - LOAD 24:00:00 → time unchanged, LOAD_ERR=1 for one cycle.
  - LOAD 12:60:00 → same response.
  - LOAD 12:0A:00 → same response.
  - In all three cases the ENABLE period is unaffected.
- Collision: assert a valid LOAD 05:05:05 on the terminal prescaler cycle → no ENABLE that cycle, time reads 05:05:05, next ENABLE 16 cycles later gives 05:05:06. Assert RESET mid-second → immediately 00:00:00.
- CNT_HMS_H12_EN: load 00:00:00, 12:00:00 and 23:00:00 → DISP_HOUR/PM read 12/0, 12/1 and 11/1 respectively.
